uart_tx_scheduler: RTL and testbench
====================================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, meaning packet byte FIFO entries (power of two, >=4).
REQ-002 The block SHALL have port i_master_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port i_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port i_pkt_data, input, 8 bits: packet byte from the MCU controller.
REQ-005 The block SHALL have port i_pkt_last, input, 1 bit: marks the final byte of a packet.
REQ-006 The block SHALL have port i_pkt_valid, input, 1 bit: the byte is offered.
REQ-007 The block SHALL have port o_pkt_ready, output, 1 bit: the FIFO accepts the byte.
REQ-008 The block SHALL have port i_vsync_pulse, input, 1 bit: single-cycle vsync event.
REQ-009 The block SHALL have port i_interrupt_pulse, input, 1 bit: single-cycle interrupt event.
REQ-010 The block SHALL have port o_enc_data, output, 8 bits: byte to the encoder.
REQ-011 The block SHALL have ports o_enc_start_request, o_enc_end_request, o_enc_vsync_request, o_enc_interrupt_request and o_enc_data_request, each output, 1 bit: the encoder command strobes.
REQ-012 The block SHALL have port i_enc_busy, input, 1 bit: encoder busy flag, which rises one cycle after an accepted request.
REQ-013 The block SHALL have ports o_vsync_overrun and o_int_overrun, each output, 1 bit: sticky lost-event flags.
REQ-014 The block SHALL have port i_clear_status, input, 1 bit: clears both overrun flags.
REQ-015 The block SHALL have port o_idle, output, 1 bit: FSM idle, FIFO empty and no event pending.

Function
REQ-016 Byte write: a byte SHALL be written when i_pkt_valid and o_pkt_ready are both high; o_pkt_ready is low when the FIFO is full. A write while full is impossible by construction.
REQ-017 Packet accounting: a complete-packet counter SHALL increment on each write with i_pkt_last=1 and decrement when a packet's last byte is popped; simultaneous increment and decrement SHALL leave it unchanged.
REQ-018 Event latches: a vsync or interrupt pulse SHALL set its pending latch.
REQ-019 Overrun: a pulse while the latch is already set and not being cleared that cycle SHALL set the matching overrun flag.
REQ-020 Same-cycle clear and pulse: a pulse in the cycle its latch is cleared by issue SHALL leave the latch set, with no overrun.
REQ-021 i_clear_status SHALL clear both overrun flags; a same-cycle overrun set SHALL win.
REQ-022 FSM states SHALL be IDLE, ISSUE, ACK and DONE, plus a phase register: EVT_INT, EVT_VS, PKT_START, PKT_DATA or PKT_END.
REQ-023 IDLE arbitration SHALL use fixed priority: interrupt pending > vsync pending > (packet count > 0 or FIFO full) -> phase PKT_START. IDLE -> ISSUE happens only when i_enc_busy=0.
REQ-024 ISSUE SHALL assert exactly one request strobe for exactly one cycle, then go to ACK.
REQ-025 o_enc_data SHALL show the FIFO head during a PKT_DATA issue and stay stable until DONE exits.
REQ-026 ACK SHALL wait for i_enc_busy=1, then go to DONE; DONE SHALL wait for i_enc_busy=0.
REQ-027 DONE exit SHALL follow the phase:
  - EVT_* -> IDLE, with the latch cleared at issue.
  - PKT_START -> PKT_DATA.
  - PKT_DATA -> pop FIFO; if the popped byte had last=1, go to PKT_END, else stay in PKT_DATA.
  - PKT_END -> IDLE.
REQ-028 Packets SHALL be atomic: no event is issued between PKT_START and PKT_END.
REQ-029 FIFO empty in PKT_DATA: the FSM SHALL hold before ISSUE until a byte arrives, with no strobe.
REQ-030 Streaming: a packet longer than FIFO_DEPTH SHALL be streamed, since the full condition starts transmission.
REQ-031 Latency: the first strobe SHALL occur 2 cycles after the triggering event is latched, given the encoder is idle.

Reset
REQ-032 While i_reset_n=0: all strobes SHALL be 0, o_enc_data 0x00, FSM IDLE, FIFO and counters empty, latches and overrun flags 0, o_pkt_ready 0.
REQ-033 o_pkt_ready SHALL become 1 on the first clock edge after release, and o_idle SHALL be 1 after release.
REQ-034 Reset mid-packet SHALL discard the partial packet; no end strobe is issued.

Structure
REQ-035 Package uart_sched_pkg SHALL hold the FSM state and phase encodings and the default FIFO_DEPTH.
REQ-036 The byte FIFO SHALL be sub-module uart_pkt_fifo (9-bit wide: data + last, synchronous, first-word fall-through).

Verification
REQ-037 Bytes 0x3C, 0xA5 (last) -> strobes in order start, data 0x3C, data 0xA5, end; each strobe 1 cycle; the next strobe only after busy 1->0.
REQ-038 Vsync and interrupt pulses in the same cycle while idle -> interrupt strobe first, then vsync; no overrun.
REQ-039 Interrupt pulse during packet data 0x11 of 3 bytes -> interrupt strobe only after the end strobe.
REQ-040 Two vsync pulses 5 cycles apart while the encoder is busy -> one vsync strobe and o_vsync_overrun=1; i_clear_status clears it.
REQ-041 20 bytes with last on the 20th and FIFO_DEPTH=16 -> start issued when full, all 20 data strobes, then end.
REQ-042 Reset asserted in ACK of the second data byte -> all strobes 0 immediately; after release o_idle=1 and no end strobe.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared encodings and defaults for the UART transmit scheduler.
package uart_sched_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 16;
    localparam int PKT_FIFO_WIDTH     = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ACK,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        PH_EVT_INT,
        PH_EVT_VS,
        PH_PKT_START,
        PH_PKT_DATA,
        PH_PKT_END
    } phase_t;

endpackage

// File: rtl/uart_pkt_fifo.sv
// Synchronous first-word-fall-through FIFO holding packet bytes with their last flag.
module uart_pkt_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Advance each pointer when its side of the FIFO actually moves.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates interrupt, vsync and packet traffic into single encoder command strobes.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic       i_master_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_pkt_data,
    input  logic       i_pkt_last,
    input  logic       i_pkt_valid,
    output logic       o_pkt_ready,
    input  logic       i_vsync_pulse,
    input  logic       i_interrupt_pulse,
    output logic [7:0] o_enc_data,
    output logic       o_enc_start_request,
    output logic       o_enc_end_request,
    output logic       o_enc_vsync_request,
    output logic       o_enc_interrupt_request,
    output logic       o_enc_data_request,
    input  logic       i_enc_busy,
    output logic       o_vsync_overrun,
    output logic       o_int_overrun,
    input  logic       i_clear_status,
    output logic       o_idle
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic          ready_q;
    logic          int_pend_q, int_pend_d, vs_pend_q, vs_pend_d;
    logic          int_ovr_q, int_ovr_d, vs_ovr_q, vs_ovr_d;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [7:0]    enc_data_q, enc_data_d;
    logic          start_req_q, start_req_d, end_req_q, end_req_d;
    logic          vs_req_q, vs_req_d, int_req_q, int_req_d, data_req_q, data_req_d;
    logic          fifo_wr, fifo_pop, fifo_empty, fifo_full;
    logic [8:0]    fifo_head;
    logic          issue_go, int_clr, vs_clr, pkt_in, pkt_out;

    assign o_pkt_ready = ready_q && !fifo_full;
    assign fifo_wr     = i_pkt_valid && o_pkt_ready;
    assign issue_go    = (state_q == ST_ISSUE) && !((phase_q == PH_PKT_DATA) && fifo_empty);
    assign fifo_pop    = (state_q == ST_DONE) && !i_enc_busy && (phase_q == PH_PKT_DATA);
    assign int_clr     = issue_go && (phase_q == PH_EVT_INT);
    assign vs_clr      = issue_go && (phase_q == PH_EVT_VS);
    assign pkt_in      = fifo_wr && i_pkt_last;
    assign pkt_out     = fifo_pop && fifo_head[8];

    assign o_enc_data              = enc_data_q;
    assign o_enc_start_request     = start_req_q;
    assign o_enc_end_request       = end_req_q;
    assign o_enc_vsync_request     = vs_req_q;
    assign o_enc_interrupt_request = int_req_q;
    assign o_enc_data_request      = data_req_q;
    assign o_vsync_overrun         = vs_ovr_q;
    assign o_int_overrun           = int_ovr_q;
    assign o_idle                  = (state_q == ST_IDLE) && fifo_empty && !int_pend_q && !vs_pend_q;

    uart_pkt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PKT_FIFO_WIDTH)
    ) u_fifo (
        .clk_i     (i_master_clk),
        .rst_ni    (i_reset_n),
        .wr_en_i   (fifo_wr),
        .wr_data_i ({i_pkt_last, i_pkt_data}),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    // FSM state and phase registers.
    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            phase_q <= PH_EVT_INT;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Next state: fixed-priority arbitration in IDLE, packets run START..END without interruption.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (!i_enc_busy) begin
                    if (int_pend_q) begin
                        phase_d = PH_EVT_INT;
                        state_d = ST_ISSUE;
                    end else if (vs_pend_q) begin
                        phase_d = PH_EVT_VS;
                        state_d = ST_ISSUE;
                    end else if ((pkt_cnt_q != '0) || fifo_full) begin
                        phase_d = PH_PKT_START;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: if (issue_go) state_d = ST_ACK;
            ST_ACK:   if (i_enc_busy) state_d = ST_DONE;
            ST_DONE: begin
                if (!i_enc_busy) begin
                    case (phase_q)
                        PH_PKT_START: begin
                            phase_d = PH_PKT_DATA;
                            state_d = ST_ISSUE;
                        end
                        PH_PKT_DATA: begin
                            state_d = ST_ISSUE;
                            if (fifo_head[8]) phase_d = PH_PKT_END;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: one strobe per issue, with the FIFO head captured for data commands.
    always_comb begin
        start_req_d = 1'b0;
        end_req_d   = 1'b0;
        vs_req_d    = 1'b0;
        int_req_d   = 1'b0;
        data_req_d  = 1'b0;
        enc_data_d  = enc_data_q;
        if (issue_go) begin
            case (phase_q)
                PH_EVT_INT:   int_req_d   = 1'b1;
                PH_EVT_VS:    vs_req_d    = 1'b1;
                PH_PKT_START: start_req_d = 1'b1;
                PH_PKT_DATA: begin
                    data_req_d = 1'b1;
                    enc_data_d = fifo_head[7:0];
                end
                default:      end_req_d   = 1'b1;
            endcase
        end
    end

    // Event latches, sticky overrun flags and the complete-packet counter.
    always_comb begin
        int_pend_d = (int_pend_q && !int_clr) || i_interrupt_pulse;
        vs_pend_d  = (vs_pend_q && !vs_clr) || i_vsync_pulse;
        int_ovr_d  = (i_interrupt_pulse && int_pend_q && !int_clr) || (int_ovr_q && !i_clear_status);
        vs_ovr_d   = (i_vsync_pulse && vs_pend_q && !vs_clr) || (vs_ovr_q && !i_clear_status);
        case ({pkt_in, pkt_out})
            2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    // Datapath registers; ready stays low until the first edge after reset release.
    always_ff @(posedge i_master_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ready_q     <= 1'b0;
            int_pend_q  <= 1'b0;
            vs_pend_q   <= 1'b0;
            int_ovr_q   <= 1'b0;
            vs_ovr_q    <= 1'b0;
            pkt_cnt_q   <= '0;
            enc_data_q  <= 8'h00;
            start_req_q <= 1'b0;
            end_req_q   <= 1'b0;
            vs_req_q    <= 1'b0;
            int_req_q   <= 1'b0;
            data_req_q  <= 1'b0;
        end else begin
            ready_q     <= 1'b1;
            int_pend_q  <= int_pend_d;
            vs_pend_q   <= vs_pend_d;
            int_ovr_q   <= int_ovr_d;
            vs_ovr_q    <= vs_ovr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            enc_data_q  <= enc_data_d;
            start_req_q <= start_req_d;
            end_req_q   <= end_req_d;
            vs_req_q    <= vs_req_d;
            int_req_q   <= int_req_d;
            data_req_q  <= data_req_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench: an encoder model logs every command, and each scenario compares
// that log with the command sequence expected from the packet/event rules.
module tb_uart_tx_scheduler;

    localparam int K_INT   = 1;
    localparam int K_VS    = 2;
    localparam int K_START = 3;
    localparam int K_DATA  = 4;
    localparam int K_END   = 5;

    logic       clk = 1'b0;
    logic       resetN;
    logic [7:0] pktData;
    logic       pktLast, pktValid, pktReady;
    logic       vsPulse, intPulse, clearStatus;
    logic [7:0] encData;
    logic       startReq, endReq, vsReq, intReq, dataReq;
    logic       encBusy;
    logic       modelBusy = 1'b0;
    logic       forceBusy = 1'b0;
    logic       vsOvr, intOvr, idle;

    int compared = 0;
    int failed = 0;
    int protoErrors = 0;
    int logQ[$];

    assign encBusy = modelBusy | forceBusy;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.FIFO_DEPTH(16)) dut (
        .i_master_clk            (clk),
        .i_reset_n               (resetN),
        .i_pkt_data              (pktData),
        .i_pkt_last              (pktLast),
        .i_pkt_valid             (pktValid),
        .o_pkt_ready             (pktReady),
        .i_vsync_pulse           (vsPulse),
        .i_interrupt_pulse       (intPulse),
        .o_enc_data              (encData),
        .o_enc_start_request     (startReq),
        .o_enc_end_request       (endReq),
        .o_enc_vsync_request     (vsReq),
        .o_enc_interrupt_request (intReq),
        .o_enc_data_request      (dataReq),
        .i_enc_busy              (encBusy),
        .o_vsync_overrun         (vsOvr),
        .o_int_overrun           (intOvr),
        .i_clear_status          (clearStatus),
        .o_idle                  (idle)
    );

    // Encoder model: logs each command, raises busy one cycle later for a random time,
    // and counts protocol violations (several strobes, strobe while busy, strobe > 1 cycle).
    initial begin : encoderModel
        int strobes;
        int kind;
        int hold;
        forever begin
            @(negedge clk);
            strobes = int'(startReq) + int'(endReq) + int'(vsReq) + int'(intReq) + int'(dataReq);
            if (resetN && strobes != 0) begin
                if (strobes > 1 || encBusy) protoErrors++;
                kind = intReq ? K_INT : vsReq ? K_VS : startReq ? K_START : dataReq ? K_DATA : K_END;
                logQ.push_back(kind * 256 + ((kind == K_DATA) ? int'(encData) : 0));
                hold = $urandom_range(1, 4);
                @(posedge clk);
                #1 modelBusy = 1'b1;
                @(negedge clk);
                if (startReq | endReq | vsReq | intReq | dataReq) protoErrors++;
                repeat (hold) @(posedge clk);
                #1 modelBusy = 1'b0;
            end
        end
    end

    // Offer one byte and wait (bounded) until the FIFO takes it.
    task automatic sendByte(input logic [7:0] d, input logic last, output bit ok);
        ok = 1'b0;
        @(posedge clk);
        #1;
        pktValid = 1'b1;
        pktData  = d;
        pktLast  = last;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (pktReady) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        pktValid = 1'b0;
        pktLast  = 1'b0;
    endtask

    // Single-cycle pulses, sampled on the second rising edge after the call.
    task automatic pulseEvent(input logic vs, input logic irq, input logic clr);
        @(posedge clk);
        #1;
        vsPulse     = vs;
        intPulse    = irq;
        clearStatus = clr;
        @(posedge clk);
        #1;
        vsPulse     = 1'b0;
        intPulse    = 1'b0;
        clearStatus = 1'b0;
    endtask

    task automatic waitLog(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            if (logQ.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic waitQuiet(output bit ok);
        int run;
        run = 0;
        ok  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            run = (idle && !encBusy) ? run + 1 : 0;
            if (run >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        logQ.delete();
    endtask

    task automatic test_reset();
        resetN = 1'b0; pktData = 8'h00; pktLast = 1'b0; pktValid = 1'b0;
        vsPulse = 1'b0; intPulse = 1'b0; clearStatus = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({startReq, endReq, vsReq, intReq, dataReq} !== 5'b0) begin
            failed++; $display("[TB] FAIL reset_strobes: got %b expected 00000", {startReq, endReq, vsReq, intReq, dataReq});
        end
        compared++;
        if (encData !== 8'h00) begin failed++; $display("[TB] FAIL reset_data: got %h expected 00", encData); end
        compared++;
        if (pktReady !== 1'b0) begin failed++; $display("[TB] FAIL reset_ready: got %b expected 0", pktReady); end
        compared++;
        if ({vsOvr, intOvr} !== 2'b00) begin failed++; $display("[TB] FAIL reset_overrun: got %b expected 00", {vsOvr, intOvr}); end
        resetN = 1'b1;
        #1;
        compared++;
        if (pktReady !== 1'b0) begin failed++; $display("[TB] FAIL ready_before_edge: got %b expected 0", pktReady); end
        @(posedge clk);
        #1;
        compared++;
        if (pktReady !== 1'b1) begin failed++; $display("[TB] FAIL ready_after_edge: got %b expected 1", pktReady); end
        compared++;
        if (idle !== 1'b1) begin failed++; $display("[TB] FAIL idle_after_reset: got %b expected 1", idle); end
    endtask

    task automatic test_basic_packet();
        int exp[$];
        bit ok, ok2;
        exp = '{K_START * 256, K_DATA * 256 + 'h3C, K_DATA * 256 + 'hA5, K_END * 256};
        waitQuiet(ok);
        sendByte(8'h3C, 1'b0, ok);
        sendByte(8'hA5, 1'b1, ok2);
        compared++;
        if (!(ok && ok2)) begin failed++; $display("[TB] FAIL basic_write: got %b%b expected 11", ok, ok2); end
        compared++;
        if (startReq !== 1'b0) begin failed++; $display("[TB] FAIL latency_cycle0: got %b expected 0", startReq); end
        @(posedge clk);
        #1;
        compared++;
        if (startReq !== 1'b0) begin failed++; $display("[TB] FAIL latency_cycle1: got %b expected 0", startReq); end
        @(posedge clk);
        #1;
        compared++;
        if (startReq !== 1'b1) begin failed++; $display("[TB] FAIL latency_cycle2: got %b expected 1", startReq); end
        @(posedge clk);
        #1;
        compared++;
        if (startReq !== 1'b0) begin failed++; $display("[TB] FAIL strobe_width: got %b expected 0", startReq); end
        waitLog(exp.size(), 1000, ok);
        compared++;
        if (logQ.size() != exp.size()) begin failed++; $display("[TB] FAIL basic_count: got %0d expected %0d", logQ.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            compared++;
            if (i >= logQ.size() || logQ[i] !== exp[i]) begin
                failed++; $display("[TB] FAIL basic_seq[%0d]: got %0h expected %0h", i, (i < logQ.size()) ? logQ[i] : -1, exp[i]);
            end
        end
    endtask

    task automatic test_event_priority();
        int exp[$];
        bit ok;
        exp = '{K_INT * 256, K_VS * 256};
        waitQuiet(ok);
        pulseEvent(1'b1, 1'b1, 1'b0);
        waitLog(exp.size(), 500, ok);
        compared++;
        if (logQ.size() != exp.size()) begin failed++; $display("[TB] FAIL prio_count: got %0d expected %0d", logQ.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            compared++;
            if (i >= logQ.size() || logQ[i] !== exp[i]) begin
                failed++; $display("[TB] FAIL prio_seq[%0d]: got %0h expected %0h", i, (i < logQ.size()) ? logQ[i] : -1, exp[i]);
            end
        end
        compared++;
        if ({vsOvr, intOvr} !== 2'b00) begin failed++; $display("[TB] FAIL prio_overrun: got %b expected 00", {vsOvr, intOvr}); end
    endtask

    task automatic test_clear_collision();
        int exp[$];
        bit ok;
        exp = '{K_VS * 256, K_VS * 256};
        waitQuiet(ok);
        pulseEvent(1'b1, 1'b0, 1'b0);
        pulseEvent(1'b1, 1'b0, 1'b0);
        waitLog(exp.size(), 500, ok);
        compared++;
        if (logQ.size() != exp.size()) begin failed++; $display("[TB] FAIL collide_count: got %0d expected %0d", logQ.size(), exp.size()); end
        compared++;
        if (vsOvr !== 1'b0) begin failed++; $display("[TB] FAIL collide_overrun: got %b expected 0", vsOvr); end
    endtask

    task automatic test_packet_atomic();
        int exp[$];
        bit ok;
        exp = '{K_START * 256, K_DATA * 256 + 'h11, K_DATA * 256 + 'h22, K_DATA * 256 + 'h33, K_END * 256, K_INT * 256};
        waitQuiet(ok);
        sendByte(8'h11, 1'b0, ok);
        sendByte(8'h22, 1'b0, ok);
        sendByte(8'h33, 1'b1, ok);
        waitLog(2, 500, ok);
        pulseEvent(1'b0, 1'b1, 1'b0);
        waitLog(exp.size(), 1000, ok);
        compared++;
        if (logQ.size() != exp.size()) begin failed++; $display("[TB] FAIL atomic_count: got %0d expected %0d", logQ.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            compared++;
            if (i >= logQ.size() || logQ[i] !== exp[i]) begin
                failed++; $display("[TB] FAIL atomic_seq[%0d]: got %0h expected %0h", i, (i < logQ.size()) ? logQ[i] : -1, exp[i]);
            end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        waitQuiet(ok);
        @(posedge clk);
        #1 forceBusy = 1'b1;
        pulseEvent(1'b1, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        pulseEvent(1'b1, 1'b0, 1'b0);
        compared++;
        if (vsOvr !== 1'b1) begin failed++; $display("[TB] FAIL vs_overrun_set: got %b expected 1", vsOvr); end
        compared++;
        if (intOvr !== 1'b0) begin failed++; $display("[TB] FAIL int_overrun_quiet: got %b expected 0", intOvr); end
        pulseEvent(1'b1, 1'b0, 1'b1);
        compared++;
        if (vsOvr !== 1'b1) begin failed++; $display("[TB] FAIL overrun_set_wins: got %b expected 1", vsOvr); end
        pulseEvent(1'b0, 1'b0, 1'b1);
        compared++;
        if (vsOvr !== 1'b0) begin failed++; $display("[TB] FAIL overrun_clear: got %b expected 0", vsOvr); end
        forceBusy = 1'b0;
        waitLog(1, 500, ok);
        compared++;
        if (logQ.size() != 1 || logQ[0] !== K_VS * 256) begin
            failed++; $display("[TB] FAIL overrun_single_vs: got %0d cmds expected 1 vsync", logQ.size());
        end
    endtask

    task automatic test_streaming();
        int exp[$];
        logic [7:0] b;
        bit ok, allOk;
        allOk = 1'b1;
        waitQuiet(ok);
        exp.push_back(K_START * 256);
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            exp.push_back(K_DATA * 256 + int'(b));
            sendByte(b, (i == 19), ok);
            allOk = allOk && ok;
            if (i == 14) begin
                repeat (10) @(posedge clk);
                compared++;
                if (logQ.size() != 0) begin failed++; $display("[TB] FAIL stream_early_start: got %0d cmds expected 0", logQ.size()); end
            end
        end
        exp.push_back(K_END * 256);
        waitLog(exp.size(), 5000, ok);
        compared++;
        if (!allOk) begin failed++; $display("[TB] FAIL stream_write: got %b expected 1", allOk); end
        compared++;
        if (logQ.size() != exp.size()) begin failed++; $display("[TB] FAIL stream_count: got %0d expected %0d", logQ.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            compared++;
            if (i >= logQ.size() || logQ[i] !== exp[i]) begin
                failed++; $display("[TB] FAIL stream_seq[%0d]: got %0h expected %0h", i, (i < logQ.size()) ? logQ[i] : -1, exp[i]);
            end
        end
    endtask

    task automatic test_random_packets();
        int exp[$];
        int len;
        logic [7:0] b;
        bit ok, allOk;
        allOk = 1'b1;
        waitQuiet(ok);
        for (int p = 0; p < 6; p++) begin
            len = $urandom_range(1, 24);
            exp.push_back(K_START * 256);
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                exp.push_back(K_DATA * 256 + int'(b));
                repeat ($urandom_range(0, 3)) @(posedge clk);
                sendByte(b, (i == len - 1), ok);
                allOk = allOk && ok;
            end
            exp.push_back(K_END * 256);
        end
        waitLog(exp.size(), 20000, ok);
        compared++;
        if (!allOk) begin failed++; $display("[TB] FAIL random_write: got %b expected 1", allOk); end
        compared++;
        if (logQ.size() != exp.size()) begin failed++; $display("[TB] FAIL random_count: got %0d expected %0d", logQ.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            compared++;
            if (i >= logQ.size() || logQ[i] !== exp[i]) begin
                failed++; $display("[TB] FAIL random_seq[%0d]: got %0h expected %0h", i, (i < logQ.size()) ? logQ[i] : -1, exp[i]);
            end
        end
        compared++;
        if (protoErrors != 0) begin failed++; $display("[TB] FAIL protocol: got %0d violations expected 0", protoErrors); end
    endtask

    task automatic test_reset_midpacket();
        bit ok, found;
        found = 1'b0;
        waitQuiet(ok);
        sendByte(8'h01, 1'b0, ok);
        sendByte(8'h02, 1'b0, ok);
        sendByte(8'h03, 1'b1, ok);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            #1;
            if (logQ.size() >= 3) begin
                found = 1'b1;
                break;
            end
        end
        compared++;
        if (!found) begin failed++; $display("[TB] FAIL midreset_reach: got %0d cmds expected 3", logQ.size()); end
        resetN = 1'b0;
        #1;
        compared++;
        if ({startReq, endReq, vsReq, intReq, dataReq} !== 5'b0) begin
            failed++; $display("[TB] FAIL midreset_strobes: got %b expected 00000", {startReq, endReq, vsReq, intReq, dataReq});
        end
        compared++;
        if (encData !== 8'h00) begin failed++; $display("[TB] FAIL midreset_data: got %h expected 00", encData); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (idle !== 1'b1) begin failed++; $display("[TB] FAIL midreset_idle: got %b expected 1", idle); end
        repeat (40) @(posedge clk);
        compared++;
        if (logQ.size() != 3) begin failed++; $display("[TB] FAIL midreset_no_end: got %0d cmds expected 3", logQ.size()); end
    endtask

    // Global time bound in case a scenario stalls outside its own budgets.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_packet();
        test_event_priority();
        test_clear_collision();
        test_packet_atomic();
        test_overrun();
        test_streaming();
        test_random_packets();
        test_reset_midpacket();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
